// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM: fetches instruction words over a
// req/ack handshake and opens the decoder's strobes only on execute and write-back cycles.
module instruction_sequencer #(
    parameter int MEM_LAT       = 2,
    parameter int FETCH_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] pc,
    output logic        rom_req,
    output logic [15:0] rom_addr,
    input  logic        rom_ack,
    input  logic [20:0] rom_data,
    output logic [20:0] ir,
    output logic [15:0] ir_addr,
    input  logic        dec_A_ce,
    input  logic        dec_REGS_ce,
    input  logic        dec_flags_ce,
    input  logic        dec_load_pc,
    input  logic        dec_load_linkreg,
    input  logic        dec_mem_we,
    output logic        A_ce,
    output logic        REGS_ce,
    output logic        flags_ce,
    output logic        load_pc,
    output logic        load_linkreg,
    output logic        mem_we,
    output logic        pc_inc,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [15:0] instr_count,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_MEMWAIT = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [20:0] ir_q, ir_d;
    logic [15:0] ir_addr_q, ir_addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic        stop_pend_q, stop_pend_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic [3:0]  wait_q, wait_d;
    logic        stop_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            ir_addr_q   <= '0;
            cnt_q       <= '0;
            fault_q     <= 1'b0;
            stop_pend_q <= 1'b0;
            to_cnt_q    <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ir_addr_q   <= ir_addr_d;
            cnt_q       <= cnt_d;
            fault_q     <= fault_d;
            stop_pend_q <= stop_pend_d;
            to_cnt_q    <= to_cnt_d;
            wait_q      <= wait_d;
        end
    end

    // A stop arriving in the very cycle of the boundary counts as pending.
    assign stop_now = stop_pend_q | stop;

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        ir_addr_d    = ir_addr_q;
        cnt_d        = cnt_q;
        fault_d      = fault_q;
        stop_pend_d  = stop_pend_q | stop;
        to_cnt_d     = '0;
        wait_d       = '0;
        rom_req      = 1'b0;
        rom_addr     = '0;
        A_ce         = 1'b0;
        REGS_ce      = 1'b0;
        flags_ce     = 1'b0;
        load_pc      = 1'b0;
        load_linkreg = 1'b0;
        mem_we       = 1'b0;
        pc_inc       = 1'b0;
        halted       = 1'b0;

        case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                if (start && !stop) state_d = S_FETCH;
            end
            S_FETCH: begin
                rom_req  = 1'b1;
                rom_addr = pc;
                if (rom_ack) begin
                    ir_d      = rom_data;
                    ir_addr_d = pc;
                    state_d   = S_DECODE;
                end else if (({1'b0, to_cnt_q} + 9'd1) == 9'(FETCH_TIMEOUT)) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                A_ce         = dec_A_ce;
                flags_ce     = dec_flags_ce;
                load_pc      = dec_load_pc;
                load_linkreg = dec_load_linkreg;
                mem_we       = dec_mem_we;
                pc_inc       = ~dec_load_pc;
                cnt_d        = cnt_q + 16'd1;
                if (dec_REGS_ce) begin
                    state_d = (MEM_LAT == 0) ? S_WB : S_MEMWAIT;
                end else if (stop_now) begin
                    state_d     = S_HALT;
                    stop_pend_d = 1'b0;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMWAIT: begin
                if (({1'b0, wait_q} + 5'd1) == 5'(MEM_LAT)) state_d = S_WB;
                else wait_d = wait_q + 4'd1;
            end
            S_WB: begin
                REGS_ce = 1'b1;
                if (stop_now) begin
                    state_d     = S_HALT;
                    stop_pend_d = 1'b0;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                halted      = 1'b1;
                stop_pend_d = 1'b0;
                if (start) begin
                    fault_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign ir          = ir_q;
    assign ir_addr     = ir_addr_q;
    assign fault       = fault_q;
    assign instr_count = cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: table of single instructions run back to back,
// then hand-written stop, fetch-timeout and reset-in-execute sequences.
module tb_instruction_sequencer;

    localparam int MEM_LAT       = 2;
    localparam int FETCH_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, rom_ack;
    logic [15:0] pc;
    logic [20:0] rom_data;
    logic [5:0]  dec;
    logic        rom_req, pc_inc, busy, halted, fault;
    logic [15:0] rom_addr, ir_addr, instr_count;
    logic [20:0] ir;
    logic        A_ce, REGS_ce, flags_ce, load_pc, load_linkreg, mem_we;
    logic [2:0]  dbg_state;
    logic [5:0]  strobes;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    instruction_sequencer #(.MEM_LAT(MEM_LAT), .FETCH_TIMEOUT(FETCH_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pc(pc),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
        .ir(ir), .ir_addr(ir_addr),
        .dec_A_ce(dec[5]), .dec_REGS_ce(dec[4]), .dec_flags_ce(dec[3]),
        .dec_load_pc(dec[2]), .dec_load_linkreg(dec[1]), .dec_mem_we(dec[0]),
        .A_ce(A_ce), .REGS_ce(REGS_ce), .flags_ce(flags_ce), .load_pc(load_pc),
        .load_linkreg(load_linkreg), .mem_we(mem_we), .pc_inc(pc_inc),
        .busy(busy), .halted(halted), .fault(fault), .instr_count(instr_count),
        .dbg_state(dbg_state)
    );

    // Bit order everywhere: {A, REGS, flags, load_pc, linkreg, mem_we}
    assign strobes = {A_ce, REGS_ce, flags_ce, load_pc, load_linkreg, mem_we};

    typedef struct {
        logic [15:0] pc;
        logic [20:0] data;
        logic [5:0]  dec;
        logic [5:0]  exp_exec;
        logic        exp_inc;
        logic        is_load;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        pc = v.pc; rom_data = v.data; rom_ack = 1'b1; dec = v.dec;
        #1;
        chk("fetch_req", {31'd0, rom_req}, 32'd1);
        chk("fetch_addr", {16'd0, rom_addr}, {16'd0, v.pc});
        chk("fetch_strb", {25'd0, strobes, pc_inc}, 32'd0);
        tick();
        rom_ack = 1'b0; rom_data = ~v.data;
        #1;
        chk("decode_strb", {24'd0, strobes, pc_inc, rom_req}, 32'd0);
        chk("decode_ir", {11'd0, ir}, {11'd0, v.data});
        chk("decode_ir_addr", {16'd0, ir_addr}, {16'd0, v.pc});
        tick();
        chk("exec_strb", {26'd0, strobes}, {26'd0, v.exp_exec});
        chk("exec_pc_inc", {31'd0, pc_inc}, {31'd0, v.exp_inc});
        exp_cnt = exp_cnt + 16'd1;
        if (v.is_load) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                tick();
                chk("memwait_strb", {25'd0, strobes, pc_inc}, 32'd0);
            end
            tick();
            chk("wb_strb", {25'd0, strobes, pc_inc}, {25'd0, 6'b010000, 1'b0});
        end
        tick();
        chk("instr_count", {16'd0, instr_count}, {16'd0, exp_cnt});
    endtask

    initial begin
        int n;
        vecs[0] = '{16'h0000, 21'h000003, 6'b101000, 6'b101000, 1'b1, 1'b0};
        vecs[1] = '{16'h0010, 21'h1A0010, 6'b000110, 6'b000110, 1'b0, 1'b0};
        vecs[2] = '{16'h0011, 21'h0C0005, 6'b010000, 6'b000000, 1'b1, 1'b1};
        vecs[3] = '{16'h0012, 21'h1FFFFF, 6'b000001, 6'b000001, 1'b1, 1'b0};
        vecs[4] = '{16'h0013, 21'h0F0F0F, 6'b111111, 6'b101111, 1'b0, 1'b1};
        vecs[5] = '{16'hFFFF, 21'h000000, 6'b000000, 6'b000000, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; stop = 1'b0; rom_ack = 1'b0;
        pc = 16'h0000; rom_data = '0; dec = '0; exp_cnt = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {25'd0, strobes, pc_inc}, 32'd0);
        chk("rst_flags", {28'd0, rom_req, busy, halted, fault}, 32'd0);
        chk("rst_ir", {11'd0, ir}, 32'd0);
        chk("rst_ir_addr", {16'd0, ir_addr}, 32'd0);
        chk("rst_count", {16'd0, instr_count}, 32'd0);
        rst = 1'b0;

        // start and stop together: stop wins, stays idle
        start = 1'b1; stop = 1'b1;
        tick();
        chk("idle_stop_wins", {30'd0, busy, rom_req}, 32'd0);
        stop = 1'b0;
        #1;
        chk("idle_no_req", {31'd0, rom_req}, 32'd0);
        tick();
        start = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // stop pulsed in DECODE: EXEC completes, then HALT
        pc = 16'h0020; rom_data = 21'h0A0001; rom_ack = 1'b1; dec = 6'b101000;
        #1;
        chk("stop_fetch_req", {31'd0, rom_req}, 32'd1);
        tick();
        rom_ack = 1'b0; stop = 1'b1;
        #1;
        chk("stop_decode_strb", {26'd0, strobes}, 32'd0);
        tick();
        stop = 1'b0;
        #1;
        chk("stop_exec_strb", {26'd0, strobes}, {26'd0, 6'b101000});
        exp_cnt = exp_cnt + 16'd1;
        tick();
        chk("stop_halted", {29'd0, halted, busy, rom_req}, 32'h4);
        chk("stop_halt_strb", {25'd0, strobes, pc_inc}, 32'd0);
        chk("stop_count", {16'd0, instr_count}, {16'd0, exp_cnt});
        pc = 16'h0021;
        tick();
        chk("halt_hold", {30'd0, halted, rom_req}, 32'h2);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("resume_req", {30'd0, rom_req, halted}, 32'h2);
        chk("resume_addr", {16'd0, rom_addr}, 32'h0021);

        // ROM never acks: fault after FETCH_TIMEOUT request cycles
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!rom_req) break;
            chk("timeout_fault_low", {31'd0, fault}, 32'd0);
            n++;
            tick();
        end
        chk("timeout_cycles", n, FETCH_TIMEOUT);
        chk("timeout_fault", {29'd0, fault, halted, rom_req}, 32'h6);
        chk("timeout_count", {16'd0, instr_count}, {16'd0, exp_cnt});

        // ack outside FETCH must not load ir
        rom_ack = 1'b1; rom_data = 21'h155555;
        tick();
        chk("ack_ignored", {11'd0, ir}, 32'h0A0001);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("restart_clears_fault", {30'd0, fault, rom_req}, 32'h1);

        // reset during EXEC drops mem_we immediately
        dec = 6'b000001;
        tick();
        rom_ack = 1'b0;
        tick();
        chk("rst_exec_we", {31'd0, mem_we}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_exec_strb", {25'd0, strobes, pc_inc}, 32'd0);
        chk("rst_exec_flags", {28'd0, rom_req, busy, halted, fault}, 32'd0);
        chk("rst_exec_count", {16'd0, instr_count}, 32'd0);
        chk("rst_exec_ir", {11'd0, ir}, 32'd0);
        chk("rst_exec_ir_addr", {16'd0, ir_addr}, 32'd0);
        tick();
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Multi-cycle control FSM between the program ROM, the instruction register and `instruction_decoder`. It fetches each instruction word through a req/ack handshake and latches it into IR/IR-address for the decoder. It then releases the decoder's enable strobes for exactly one execute cycle, inserts memory-read wait states for register loads, and handles start/stop/fault sequencing. All architectural state changes (accumulator, register file, flags, PC, link register, data memory) happen only on cycles this block allows.

## Interface
- `MEM_LAT`, 2: wait cycles between load issue and register-file write (0..15).
- `FETCH_TIMEOUT`, 8: max cycles `rom_req` may stay unacknowledged before a fault (1..255).
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level; leaves IDLE/HALT.
- `stop` in 1: pulse; halt request, latched until honoured.
- `pc` in 16: current program counter value.
- `rom_req` out 1: fetch request.
- `rom_addr` out 16: fetch address.
- `rom_ack` in 1: ROM data valid.
- `rom_data` in 21: instruction word.
- `ir` out 21: latched instruction, drives decoder `INS`.
- `ir_addr` out 16: address of `ir`, drives decoder `INS_addr`.
- `dec_A_ce`, `dec_REGS_ce`, `dec_flags_ce`, `dec_load_pc`, `dec_load_linkreg`, `dec_mem_we` in 1 each: raw decoder strobes.
- `A_ce`, `REGS_ce`, `flags_ce`, `load_pc`, `load_linkreg`, `mem_we` out 1 each: gated strobes to the datapath.
- `pc_inc` out 1: PC += 1 this cycle.
- `busy` out 1: not in IDLE/HALT.
- `halted` out 1: in HALT.
- `fault` out 1: sticky fetch-timeout flag.
- `instr_count` out 16: retired instruction counter.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEMWAIT, WB, HALT.
- IDLE: wait for `start` while `stop` is low, then go to FETCH. If `start` and `stop` are both high, stay in IDLE (stop wins).
- FETCH: `rom_req`=1 and `rom_addr`=`pc`.
  - On `rom_ack`: `ir`<=`rom_data` and `ir_addr`<=`pc`, then go to DECODE.
  - A timeout counter increments each unacknowledged cycle. When it reaches `FETCH_TIMEOUT`, set `fault`=1, deassert `rom_req` and go to HALT.
- DECODE: one settle cycle; all gated strobes are 0. Go to EXEC.
- EXEC, exactly one cycle:
  - `A_ce`, `flags_ce`, `load_pc`, `load_linkreg` and `mem_we` equal their `dec_*` inputs.
  - `REGS_ce`=0.
  - `pc_inc`=~`dec_load_pc`.
  - `instr_count` increments and wraps FFFF->0000.
  - Next state: if `dec_REGS_ce`, go to MEMWAIT (or straight to WB if `MEM_LAT`=0). Otherwise go to the boundary check.
- MEMWAIT: count `MEM_LAT` cycles, then go to WB.
- WB: `REGS_ce`=1 for one cycle, then go to the boundary check.
- Boundary check, applied at the end of EXEC/WB: if `stop` is pending, go to HALT and clear the pending flag; else go to FETCH.
- `stop` is latched in any state except IDLE/HALT and is honoured only at an instruction boundary. An instruction in flight always completes.
- HALT: all strobes are 0 and `halted`=1. On `start`, clear `fault` and go to FETCH.
- Outside EXEC/WB every gated output is 0, whatever the `dec_*` inputs are.
- `rom_ack` outside FETCH is ignored.

## Timing
- Reset, asynchronous: state=IDLE; `ir`=0, `ir_addr`=0, `instr_count`=0; `fault`=0; stop-pending=0; all strobes, `rom_req`, `pc_inc`, `busy` and `halted` = 0.
- Reset mid-instruction aborts immediately: no strobe may be seen high after `rst` rises.
- Gated outputs are combinational from state and `dec_*`. `ir` and `ir_addr` are registered.
- Latency with zero-wait ROM (`rom_ack` in the first FETCH cycle):
  - Non-load instruction: 3 cycles (FETCH, DECODE, EXEC).
  - Load: 4+`MEM_LAT` cycles.
- PC changes only at the EXEC clock edge, so the next FETCH sees the updated `pc`.
- `rom_addr` is held stable while `rom_req`=1.
- The timeout counter resets on each FETCH entry.

## Test plan
- Reset, then `start`=1, ROM acks immediately, `rom_data`=21'h000003 (ALU op, decoder gives A_ce=flags_ce=1) -> `rom_req` high at cycle 1; A_ce=flags_ce=pc_inc=1 only in cycle 3; `instr_count`=1.
- Jump (`dec_load_pc`=1, `dec_load_linkreg`=1) at `pc`=16'h0010 -> load_pc=load_linkreg=1 and pc_inc=0 for one cycle; `ir_addr`=16'h0010.
- Load (`dec_REGS_ce`=1) with `MEM_LAT`=2 -> REGS_ce=1 exactly in cycle 6 after FETCH entry; other strobes stay 0 in MEMWAIT.
- `stop` pulsed during DECODE -> EXEC completes, next state HALT, `halted`=1, `rom_req` stays 0; `start` resumes with a fetch at the current `pc`.
- ROM never acks with `FETCH_TIMEOUT`=8 -> `fault`=1 after 8 FETCH cycles, HALT, and `instr_count` unchanged.
- `rst` asserted during EXEC with `dec_mem_we`=1 -> `mem_we` drops in the same cycle; all outputs read reset values; `instr_count`=0.
